// File: rtl/game_timer_score_unit.sv
// Countdown, game and difficulty timers plus hit scoring for the game FSM.
// Optional macro MISS_PENALTY_EN: a scored timeout without a hit costs one point.
module game_timer_score_unit #(
    parameter int COUNTDOWN_LEN = 5,
    parameter int GAME_LEN      = 30,
    parameter int SCORE_MAX     = 255,
    parameter int DIFF_STEP_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_1hz,
    input  logic       enable_countdown,
    input  logic       clear_countdown,
    input  logic       enable_game_timer,
    input  logic       clear_game_timer,
    input  logic       enable_score,
    input  logic       clear_score,
    input  logic       enable_difficulty_timer,
    input  logic [1:0] difficulty_level,
    input  logic       hit_pulse,
    input  logic       timeout_pulse,
    output logic [5:0] countdown_sec,
    output logic [5:0] game_time_sec,
    output logic [7:0] score,
    output logic       countdown_done,
    output logic       game_done,
    output logic       diff_tick,
    output logic       sec_tick
);

    localparam logic [5:0] CD_MAX = 6'(COUNTDOWN_LEN);
    localparam logic [5:0] GT_MAX = 6'(GAME_LEN);
    localparam logic [5:0] DS_MAX = 6'(DIFF_STEP_SEC);
    localparam logic [8:0] SC_MAX = 9'(SCORE_MAX);

    logic       s0, s1, s2;
    logic [5:0] diff_cnt;
    logic [3:0] streak;
    logic [3:0] streak_inc;
    logic [3:0] streak_n;
    logic [1:0] points;
    logic       bonus;
    logic [8:0] sum;
    logic [7:0] score_n;

    // Flops preset high so a reset release with clk_1hz high is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s0 <= clk_1hz;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign sec_tick = s1 & ~s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countdown_sec <= 6'd0;
        end else if (clear_countdown) begin
            countdown_sec <= 6'd0;
        end else if (sec_tick && enable_countdown
                     && countdown_sec < CD_MAX) begin
            countdown_sec <= countdown_sec + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            game_time_sec <= 6'd0;
        end else if (clear_game_timer) begin
            game_time_sec <= 6'd0;
        end else if (sec_tick && enable_game_timer
                     && game_time_sec < GT_MAX) begin
            game_time_sec <= game_time_sec + 6'd1;
        end
    end

    assign countdown_done = (countdown_sec == CD_MAX);
    assign game_done      = (game_time_sec == GT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_cnt  <= 6'd0;
            diff_tick <= 1'b0;
        end else begin
            diff_tick <= 1'b0;
            if (clear_game_timer) begin
                diff_cnt <= 6'd0;
            end else if (sec_tick && enable_difficulty_timer) begin
                if (diff_cnt + 6'd1 == DS_MAX) begin
                    diff_cnt  <= 6'd0;
                    diff_tick <= 1'b1;
                end else begin
                    diff_cnt <= diff_cnt + 6'd1;
                end
            end
        end
    end

    always_comb begin
        points = 2'd3;
        unique case (1'b1)
            difficulty_level == 2'b00: points = 2'd1;
            difficulty_level == 2'b01: points = 2'd2;
            default:                   points = 2'd3;
        endcase
        streak_inc = (streak == 4'hF) ? 4'hF : streak + 4'd1;
        bonus = (streak_inc == 4'd5) || (streak_inc == 4'd10)
                || (streak_inc == 4'd15);
        sum = {1'b0, score} + {7'd0, points} + {8'd0, bonus};
        if (sum > SC_MAX) begin
            sum = SC_MAX;
        end
        score_n  = score;
        streak_n = streak;
        if (clear_score) begin
            score_n  = 8'd0;
            streak_n = 4'd0;
        end else if (enable_score) begin
            if (hit_pulse) begin
                score_n  = sum[7:0];
                streak_n = timeout_pulse ? 4'd0 : streak_inc;
            end else if (timeout_pulse) begin
                streak_n = 4'd0;
`ifdef MISS_PENALTY_EN
                if (score != 8'd0) begin
                    score_n = score - 8'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score  <= 8'd0;
            streak <= 4'd0;
        end else begin
            score  <= score_n;
            streak <= streak_n;
        end
    end

endmodule

// File: tb/tb_game_timer_score_unit.sv
// Scoreboard bench for game_timer_score_unit: directed plan then random traffic
// against a second-granularity reference model.
module tb_game_timer_score_unit;

    localparam int CL   = 5;
    localparam int GL   = 30;
    localparam int SM   = 255;
    localparam int STEP = 10;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_1hz = 1'b1;
    logic       enable_countdown = 1'b0;
    logic       clear_countdown = 1'b0;
    logic       enable_game_timer = 1'b0;
    logic       clear_game_timer = 1'b0;
    logic       enable_score = 1'b0;
    logic       clear_score = 1'b0;
    logic       enable_difficulty_timer = 1'b0;
    logic [1:0] difficulty_level = 2'b00;
    logic       hit_pulse = 1'b0;
    logic       timeout_pulse = 1'b0;
    logic [5:0] countdown_sec;
    logic [5:0] game_time_sec;
    logic [7:0] score;
    logic       countdown_done;
    logic       game_done;
    logic       diff_tick;
    logic       sec_tick;

    always #5 clk = ~clk;

    game_timer_score_unit #(
        .COUNTDOWN_LEN(CL),
        .GAME_LEN(GL),
        .SCORE_MAX(SM),
        .DIFF_STEP_SEC(STEP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_1hz(clk_1hz),
        .enable_countdown(enable_countdown),
        .clear_countdown(clear_countdown),
        .enable_game_timer(enable_game_timer),
        .clear_game_timer(clear_game_timer),
        .enable_score(enable_score),
        .clear_score(clear_score),
        .enable_difficulty_timer(enable_difficulty_timer),
        .difficulty_level(difficulty_level),
        .hit_pulse(hit_pulse),
        .timeout_pulse(timeout_pulse),
        .countdown_sec(countdown_sec),
        .game_time_sec(game_time_sec),
        .score(score),
        .countdown_done(countdown_done),
        .game_done(game_done),
        .diff_tick(diff_tick),
        .sec_tick(sec_tick)
    );

    typedef struct {
        int cd;
        int gt;
        int sc;
        bit cdd;
        bit gd;
        bit dt;
        bit st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference state: seconds counted, total enabled difficulty seconds.
    int   m_cd = 0;
    int   m_gt = 0;
    int   m_sc = 0;
    int   m_st = 0;
    int   m_dsec = 0;
    bit   m_dt = 0;
    bit   hist[$] = '{1'b1, 1'b1, 1'b1};
    bit   rand_1hz = 0;
    int   half_cnt = HALF;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // A clk_1hz rise seen two samples back becomes a tick on the coming edge.
    function automatic bit tick_pending();
        return hist[hist.size()-2] && !hist[hist.size()-3];
    endfunction

    task automatic cyc();
        exp_t e;
        bit   tk;
        int   pts;
        int   stk;
        tk = tick_pending();
        if (clear_countdown) m_cd = 0;
        else if (tk && enable_countdown && m_cd < CL) m_cd++;
        if (clear_game_timer) m_gt = 0;
        else if (tk && enable_game_timer && m_gt < GL) m_gt++;
        m_dt = 0;
        if (clear_game_timer) begin
            m_dsec = 0;
        end else if (tk && enable_difficulty_timer) begin
            m_dsec++;
            m_dt = (m_dsec % STEP) == 0;
        end
        if (clear_score) begin
            m_sc = 0;
            m_st = 0;
        end else if (enable_score) begin
            if (hit_pulse) begin
                stk = (m_st < 15) ? m_st + 1 : 15;
                pts = (difficulty_level == 0) ? 1 :
                      (difficulty_level == 1) ? 2 : 3;
                if (stk % 5 == 0) pts++;
                m_sc = (m_sc + pts > SM) ? SM : m_sc + pts;
                m_st = timeout_pulse ? 0 : stk;
            end else if (timeout_pulse) begin
                m_st = 0;
`ifdef MISS_PENALTY_EN
                if (m_sc > 0) m_sc--;
`endif
            end
        end
        hist.push_back(clk_1hz);
        if (hist.size() > 4) void'(hist.pop_front());
        e.cd  = m_cd;
        e.gt  = m_gt;
        e.sc  = m_sc;
        e.cdd = (m_cd == CL);
        e.gd  = (m_gt == GL);
        e.dt  = m_dt;
        e.st  = tick_pending();
        sb.push_back(e);
        @(negedge clk);
        half_cnt--;
        if (half_cnt == 0) begin
            clk_1hz = ~clk_1hz;
            half_cnt = rand_1hz ? int'($urandom_range(3, 10)) : HALF;
        end
    endtask

    task automatic secs(int n);
        repeat (n * 2 * HALF) cyc();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("countdown_sec", int'(countdown_sec), mon_e.cd);
                chk("game_time_sec", int'(game_time_sec), mon_e.gt);
                chk("score", int'(score), mon_e.sc);
                chk("countdown_done", int'(countdown_done), int'(mon_e.cdd));
                chk("game_done", int'(game_done), int'(mon_e.gd));
                chk("diff_tick", int'(diff_tick), int'(mon_e.dt));
                chk("sec_tick", int'(sec_tick), int'(mon_e.st));
            end
        end
    end

    initial begin
        int w;
        int pulses;
        repeat (3) @(negedge clk);
        chk("rst_score", int'(score), 0);
        chk("rst_tick", int'(sec_tick), 0);
        rst_n = 1'b1;
        chk("rst_cd", int'(countdown_sec), 0);
        chk("rst_diff", int'(diff_tick), 0);

        secs(3);
        chk("idle_cd", int'(countdown_sec), 0);
        chk("idle_gt", int'(game_time_sec), 0);

        enable_countdown = 1'b1;
        secs(7);
        chk("cd_sat", int'(countdown_sec), 5);
        chk("cd_done", int'(countdown_done), 1);
        clear_countdown = 1'b1;
        cyc();
        clear_countdown = 1'b0;
        chk("cd_clear", int'(countdown_sec), 0);
        enable_countdown = 1'b0;

        enable_game_timer = 1'b1;
        secs(32);
        chk("gt_sat", int'(game_time_sec), 30);
        chk("gt_done", int'(game_done), 1);
        clear_game_timer = 1'b1;
        cyc();
        clear_game_timer = 1'b0;
        secs(3);
        w = 0;
        while (!tick_pending() && w < 64) begin
            cyc();
            w++;
        end
        chk("tick_before_clear", int'(sec_tick), 1);
        clear_game_timer = 1'b1;
        cyc();
        clear_game_timer = 1'b0;
        chk("gt_clear_tick", int'(game_time_sec), 0);
        enable_game_timer = 1'b0;

        begin
            int exp4[7] = '{2, 4, 6, 8, 11, 13, 15};
            enable_score = 1'b1;
            difficulty_level = 2'b01;
            clear_score = 1'b1;
            cyc();
            clear_score = 1'b0;
            for (int i = 0; i < 7; i++) begin
                hit_pulse = 1'b1;
                timeout_pulse = (i == 5);
                cyc();
                hit_pulse = 1'b0;
                timeout_pulse = 1'b0;
                chk("score_seq", int'(score), exp4[i]);
                cyc();
            end
        end

        clear_score = 1'b1;
        cyc();
        clear_score = 1'b0;
        difficulty_level = 2'b10;
        for (int i = 0; i < 84; i++) begin
            hit_pulse = 1'b1;
            timeout_pulse = (i % 4 == 3);
            cyc();
        end
        hit_pulse = 1'b0;
        timeout_pulse = 1'b0;
        chk("score_252", int'(score), 252);
        difficulty_level = 2'b01;
        hit_pulse = 1'b1;
        timeout_pulse = 1'b1;
        cyc();
        timeout_pulse = 1'b0;
        chk("score_254", int'(score), 254);
        difficulty_level = 2'b11;
        cyc();
        chk("score_clamp", int'(score), 255);
        clear_score = 1'b1;
        cyc();
        clear_score = 1'b0;
        hit_pulse = 1'b0;
        chk("score_clear_hit", int'(score), 0);

        clear_game_timer = 1'b1;
        cyc();
        clear_game_timer = 1'b0;
        enable_difficulty_timer = 1'b1;
        pulses = 0;
        repeat (25 * 2 * HALF) begin
            cyc();
            if (diff_tick) pulses++;
        end
        chk("diff_pulses", pulses, 2);
        enable_difficulty_timer = 1'b0;

        difficulty_level = 2'b00;
        timeout_pulse = 1'b1;
        cyc();
        timeout_pulse = 1'b0;
        chk("miss_floor", int'(score), 0);
        repeat (3) begin
            hit_pulse = 1'b1;
            cyc();
            hit_pulse = 1'b0;
        end
        timeout_pulse = 1'b1;
        cyc();
        timeout_pulse = 1'b0;
`ifdef MISS_PENALTY_EN
        chk("miss_penalty", int'(score), 2);
`else
        chk("miss_penalty", int'(score), 3);
`endif

        rand_1hz = 1'b1;
        repeat (1500) begin
            enable_countdown        = ($urandom_range(0, 3) != 0);
            enable_game_timer       = ($urandom_range(0, 3) != 0);
            enable_score            = ($urandom_range(0, 7) != 0);
            enable_difficulty_timer = ($urandom_range(0, 3) != 0);
            clear_countdown         = ($urandom_range(0, 59) == 0);
            clear_game_timer        = ($urandom_range(0, 79) == 0);
            clear_score             = ($urandom_range(0, 99) == 0);
            difficulty_level        = 2'($urandom_range(0, 3));
            hit_pulse               = ($urandom_range(0, 2) == 0);
            timeout_pulse           = ($urandom_range(0, 5) == 0);
            cyc();
        end
        hit_pulse = 1'b0;
        timeout_pulse = 1'b0;
        clear_countdown = 1'b0;
        clear_game_timer = 1'b0;
        clear_score = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_timer_score_unit.md
Name: game_timer_score_unit

Overview:
Datapath companion to the game control FSM. Consumes the FSM's enable/clear strobes, the 1 Hz clock and the mole hit/timeout pulses, and produces countdown_sec, game_time_sec and score for the FSM's transition and display logic. Also generates the periodic difficulty-step pulse. Fully synchronous to clk; clk_1hz is sampled only as data.

Parameters:
COUNTDOWN_LEN, 5, countdown length in seconds; countdown_sec saturates here.
GAME_LEN, 30, round length in seconds; game_time_sec saturates here.
SCORE_MAX, 255, score saturation ceiling (must be at most 255).
DIFF_STEP_SEC, 10, seconds of enabled difficulty timer per diff_tick pulse (range 1..63).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_1hz  in  1  1 Hz square wave, asynchronous to clk
enable_countdown  in  1  countdown counter advances on seconds
clear_countdown  in  1  zero countdown counter
enable_game_timer  in  1  game timer advances on seconds
clear_game_timer  in  1  zero game timer and difficulty timer
enable_score  in  1  hits/timeouts affect score
clear_score  in  1  zero score and streak
enable_difficulty_timer  in  1  difficulty timer advances on seconds
difficulty_level  in  2  00 easy, 01 medium, 10 hard, 11 treated as hard
hit_pulse  in  1  one-cycle mole-hit strobe
timeout_pulse  in  1  one-cycle mole-missed strobe
countdown_sec  out  6  elapsed countdown seconds
game_time_sec  out  6  elapsed game seconds
score  out  8  current score
countdown_done  out  1  countdown_sec == COUNTDOWN_LEN
game_done  out  1  game_time_sec == GAME_LEN
diff_tick  out  1  one-cycle difficulty-step pulse
sec_tick  out  1  one-cycle pulse per clk_1hz rising edge

Behaviour:
- Reset (async, rst_n low): all counters, score, streak, diff_tick = 0. Synchroniser flops s0/s1/s2 = 1, so releasing reset while clk_1hz is high produces no tick.
- Tick generation: s0<=clk_1hz, s1<=s0, s2<=s1. sec_tick = s1 & ~s2 (combinational). sec_tick is high for exactly one clk cycle per clk_1hz rising edge, about 2 clk edges after the edge.
- Countdown counter, per clk edge, in priority order:
  - clear_countdown: set 0.
  - sec_tick & enable_countdown & countdown_sec < COUNTDOWN_LEN: increment.
  - Otherwise hold. The counter saturates and never wraps.
- Game timer: same rules using clear_game_timer, enable_game_timer and GAME_LEN.
- countdown_done and game_done are combinational compares of the registered counters.
- Difficulty timer:
  - Internal 6-bit counter. clear_game_timer zeroes it (priority).
  - On sec_tick & enable_difficulty_timer, the counter increments. When it reaches DIFF_STEP_SEC it reloads 0 and diff_tick is registered high for the next cycle only.
  - When disabled, the counter holds its value and does not clear.
- Score points per hit: easy 1, medium 2, hard 3.
- Streak: 4-bit counter, saturates at 15.
- Score update, per clk edge, in priority order:
  - clear_score: score = 0, streak = 0; a hit in the same cycle is ignored.
  - enable_score low: hits and timeouts are ignored; score and streak hold.
  - hit_pulse: streak_n = streak+1 (saturating). Score += points, plus 1 bonus if streak_n is 5, 10 or 15. The sum is computed 9 bits wide and clamped to SCORE_MAX.
  - timeout_pulse: streak = 0.
  - hit_pulse and timeout_pulse together: the hit is scored with bonus computed as above, then streak = 0.
- Outputs are registered; score, countdown_sec and game_time_sec change one clk after the qualifying cycle.

Optional Feature:
MISS_PENALTY_EN:
- Defined: a timeout_pulse with enable_score and no simultaneous hit_pulse decrements score by 1, floored at 0, and zeroes the streak.
- Undefined: timeout_pulse only zeroes the streak; score is unchanged.

Test Plan:
1. Release reset with clk_1hz=1, then hold enables low for 3 s: sec_tick stays 0 until the next clk_1hz rising edge; all outputs remain 0.
2. enable_countdown=1 for 7 clk_1hz edges: countdown_sec steps 1..5 and saturates at 5; countdown_done=1 from the 5th step. clear_countdown pulse returns it to 0 next cycle.
3. enable_game_timer=1 for 32 s: game_time_sec saturates at 30 and game_done=1. clear_game_timer together with a sec_tick: result is 0.
4. difficulty_level=01, enable_score=1, 5 hits: score reads 2,4,6,8,11. Then hit+timeout in the same cycle: score 13, streak 0. Then 1 hit: score 15.
5. Preload score to 254 (hard, no bonus), then hit: score = 255. clear_score asserted with hit_pulse: score = 0.
6. enable_difficulty_timer=1, DIFF_STEP_SEC=10, 25 s: diff_tick pulses exactly twice, each one clk wide. With MISS_PENALTY_EN and score=0, timeout: score stays 0; with score=3, timeout: score = 2.
